// File: rtl/posit_accum_round_16_es2_pkg.sv
// Constants, per-stage records and the regime placement shifter for the
// es=2 accumulator-to-posit16 rounding pipeline.
package posit_accum_round_16_es2_pkg;

   localparam int FBITS_ACCUM          = 24;
   localparam int POSIT16_ES2_MAXSCALE = 56;
   localparam int CBITS                = 7;   // clamped scale range [-56, 56]
   localparam int KBITS                = 5;
   localparam int MBITS                = 15;
   // Seed {run, stop, e, fraction} plus room for a 14-bit regime shift so no bit is lost.
   localparam int PAD                  = 14;
   localparam int RBITS                = FBITS_ACCUM + 4 + PAD;

   typedef struct packed {
      logic                   sgn;
      logic [KBITS-1:0]       k;
      logic [1:0]             e;
      logic [FBITS_ACCUM-1:0] fraction;
      logic                   sat;
      logic                   inf;
      logic                   zero;
      logic                   trunc;
   } value_accum_prod_cls;

   typedef struct packed {
      logic             sgn;
      logic [MBITS-1:0] mag;
      logic             guard;
      logic             sticky;
      logic             sat;
      logic             inf;
      logic             zero;
      logic             trunc;
   } value_accum_prod_rnd;

   function automatic logic [RBITS-1:0] shift_right(input logic [RBITS-1:0] v,
                                                    input logic [3:0]       amt,
                                                    input logic             fill);
      logic [2*RBITS-1:0] t;
      t = {{RBITS{fill}}, v} >> amt;
      return t[RBITS-1:0];
   endfunction

endpackage

// File: rtl/posit_accum_round_16_es2_rne.sv
// Combinational round-to-nearest-even increment on a 15-bit posit magnitude,
// saturating so the result stays within [1, 7FFF].
module posit_rne_round_16 (
   input  logic [14:0] mag_i,
   input  logic        inc_i,
   output logic [14:0] mag_o
);

   logic [15:0] sum;

   always_comb begin
      sum = {1'b0, mag_i} + {15'b0, inc_i};
      if (sum[15]) begin
         mag_o = 15'h7FFF;
      end else if (sum[14:0] == 15'h0000) begin
         mag_o = 15'h0001;
      end else begin
         mag_o = sum[14:0];
      end
   end

endmodule

// File: rtl/posit_accum_round_16_es2.sv
// Encodes a raw accumulator value as a 16-bit es=2 posit with RNE and saturation.
// Three register stages (classify, assemble, round); no backpressure.
module posit_accum_round_16_es2
   import posit_accum_round_16_es2_pkg::*;
#(
   parameter int FBITS = FBITS_ACCUM,
   parameter int SBITS = 9,
   parameter int NBITS = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sgn,
   input  logic signed [SBITS-1:0] in_scale,
   input  logic [FBITS-1:0]        in_fraction,
   input  logic                    in_inf,
   input  logic                    in_zero,
   input  logic                    in_truncated,
   output logic                    out_valid,
   output logic [NBITS-1:0]        out_posit,
   output logic                    out_inexact
);

   localparam logic signed [SBITS-1:0] SCALE_HI = SBITS'(POSIT16_ES2_MAXSCALE);
   localparam logic signed [SBITS-1:0] SCALE_LO = -SCALE_HI;
   localparam logic signed [CBITS-1:0] CLAMP_HI = CBITS'(POSIT16_ES2_MAXSCALE);
   localparam logic signed [CBITS-1:0] CLAMP_LO = -CLAMP_HI;

   logic                v1_q, v2_q, out_valid_q;
   value_accum_prod_cls s1_d, s1_q;
   value_accum_prod_rnd s2_d, s2_q;
   logic [NBITS-1:0]    posit_d, out_posit_q;
   logic                inexact_d, out_inexact_q;

   logic signed [CBITS-1:0] scale_c;
   logic                    sat_c;
   logic                    fill_c;
   logic [3:0]              amt_c;
   logic [RBITS-1:0]        body_c;
   logic                    rne_inc;
   logic [MBITS-1:0]        mag_rnd;

   always_comb begin
      scale_c = in_scale[CBITS-1:0];
      sat_c   = 1'b0;
      if (in_scale > SCALE_HI) begin
         scale_c = CLAMP_HI;
         sat_c   = 1'b1;
      end else if (in_scale < SCALE_LO) begin
         scale_c = CLAMP_LO;
         sat_c   = 1'b1;
      end
      s1_d.sgn      = in_sgn;
      s1_d.k        = scale_c[CBITS-1:2];
      s1_d.e        = scale_c[1:0];
      s1_d.fraction = in_fraction;
      s1_d.sat      = sat_c;
      s1_d.inf      = in_inf;
      s1_d.zero     = in_zero;
      s1_d.trunc    = in_truncated;
   end

   // Positive k: run of ones shifted in by k; negative k: run of zeros by -k-1 (= ~k).
   always_comb begin
      fill_c      = ~s1_q.k[KBITS-1];
      amt_c       = fill_c ? s1_q.k[3:0] : ~s1_q.k[3:0];
      body_c      = shift_right({fill_c, ~fill_c, s1_q.e, s1_q.fraction, {PAD{1'b0}}},
                                amt_c, fill_c);
      s2_d.sgn    = s1_q.sgn;
      s2_d.mag    = body_c[RBITS-1 -: MBITS];
      s2_d.guard  = body_c[RBITS-1-MBITS];
      s2_d.sticky = |body_c[RBITS-2-MBITS:0];
      s2_d.sat    = s1_q.sat;
      s2_d.inf    = s1_q.inf;
      s2_d.zero   = s1_q.zero;
      s2_d.trunc  = s1_q.trunc;
   end

   assign rne_inc = s2_q.guard & (s2_q.sticky | s2_q.mag[0]);

   posit_rne_round_16 u_rne (
      .mag_i (s2_q.mag),
      .inc_i (rne_inc),
      .mag_o (mag_rnd)
   );

   always_comb begin
      posit_d   = s2_q.sgn ? -{1'b0, mag_rnd} : {1'b0, mag_rnd};
      inexact_d = s2_q.trunc | s2_q.guard | s2_q.sticky | s2_q.sat;
      if (s2_q.inf) begin
         posit_d   = 16'h8000;
         inexact_d = 1'b0;
      end else if (s2_q.zero) begin
         posit_d   = 16'h0000;
         inexact_d = s2_q.trunc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q          <= 1'b0;
         v2_q          <= 1'b0;
         out_valid_q   <= 1'b0;
         s1_q          <= '0;
         s2_q          <= '0;
         out_posit_q   <= '0;
         out_inexact_q <= 1'b0;
      end else begin
         v1_q        <= in_valid;
         v2_q        <= v1_q;
         out_valid_q <= v2_q;
         if (in_valid) s1_q <= s1_d;
         if (v1_q)     s2_q <= s2_d;
         if (v2_q) begin
            out_posit_q   <= posit_d;
            out_inexact_q <= inexact_d;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_posit   = out_posit_q;
   assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_posit_accum_round_16_es2.sv
// Directed bench for posit_accum_round_16_es2 with a latency-tagged expected queue.
module tb_posit_accum_round_16_es2;

   logic               clk;
   logic               rst;
   logic               in_valid;
   logic               in_sgn;
   logic signed [8:0]  in_scale;
   logic [23:0]        in_fraction;
   logic               in_inf;
   logic               in_zero;
   logic               in_truncated;
   logic               out_valid;
   logic [15:0]        out_posit;
   logic               out_inexact;

   typedef struct {
      logic [15:0] posit;
      logic        inexact;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   logic [15:0] last_posit   = 16'h0000;
   logic        last_inexact = 1'b0;

   posit_accum_round_16_es2 dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_sgn       (in_sgn),
      .in_scale     (in_scale),
      .in_fraction  (in_fraction),
      .in_inf       (in_inf),
      .in_zero      (in_zero),
      .in_truncated (in_truncated),
      .out_valid    (out_valid),
      .out_posit    (out_posit),
      .out_inexact  (out_inexact)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      exp_t e;
      logic due_now;
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $error("FAIL lost cyc=%0d observed=none expected=%h due=%0d", cyc, e.posit, e.due);
      end
      due_now = (sb.size() > 0) && (sb[0].due == cyc);
      checks++;
      assert (out_valid === due_now) else begin
         errors++;
         $error("FAIL valid cyc=%0d observed=%b expected=%b", cyc, out_valid, due_now);
      end
      if (due_now) begin
         e = sb.pop_front();
         checks++;
         assert (out_posit === e.posit) else begin
            errors++;
            $error("FAIL posit cyc=%0d observed=%h expected=%h", cyc, out_posit, e.posit);
         end
         checks++;
         assert (out_inexact === e.inexact) else begin
            errors++;
            $error("FAIL inexact cyc=%0d observed=%b expected=%b", cyc, out_inexact, e.inexact);
         end
         last_posit   = e.posit;
         last_inexact = e.inexact;
      end else begin
         checks++;
         assert (out_posit === last_posit && out_inexact === last_inexact) else begin
            errors++;
            $error("FAIL hold cyc=%0d observed=%h/%b expected=%h/%b",
                   cyc, out_posit, out_inexact, last_posit, last_inexact);
         end
      end
   endtask

   task automatic drive(input logic sgn, input logic signed [8:0] scale, input logic [23:0] frac,
                        input logic inf, input logic zero, input logic trunc,
                        input logic push, input logic [15:0] ep, input logic ei);
      exp_t e;
      in_valid     = 1'b1;
      in_sgn       = sgn;
      in_scale     = scale;
      in_fraction  = frac;
      in_inf       = inf;
      in_zero      = zero;
      in_truncated = trunc;
      if (push) begin
         e.posit   = ep;
         e.inexact = ei;
         e.due     = cyc + 3;
         sb.push_back(e);
      end
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid     = 1'b0;
         in_sgn       = 1'bx;
         in_scale     = 'x;
         in_fraction  = 'x;
         in_inf       = 1'bx;
         in_zero      = 1'bx;
         in_truncated = 1'bx;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(1);

      // sgn scale frac inf zero trunc push expected inexact
      drive(1'b0,  9'sd0,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0);
      drive(1'b1,  9'sd0,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hC000, 1'b0);
      drive(1'b0,  9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4800, 1'b0);
      drive(1'b0, -9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3800, 1'b0);
      drive(1'b0,  9'sd56,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      drive(1'b0,  9'sd100, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1);
      drive(1'b1, -9'sd100, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
      drive(1'b0, -9'sd56,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
      drive(1'b0,  9'sd0,   24'h001000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b1);
      drive(1'b0,  9'sd0,   24'h001010, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4001, 1'b1);
      drive(1'b0,  9'sd0,   24'h003000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4002, 1'b1);
      drive(1'b0,  9'sd5,   24'h000000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0);
      drive(1'b1,  9'sd3,   24'h123456, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
      drive(1'b0,  9'sd2,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5000, 1'b0);
      drive(1'b0,  9'sd4,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h6000, 1'b0);
      drive(1'b0, -9'sd4,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b0);
      drive(1'b1,  9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hB800, 1'b0);
      drive(1'b0,  9'sd55,  24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1);
      drive(1'b0,  9'sd0,   24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b1);
      idle(4);

      // five back-to-back, one idle cycle with X data, two more
      drive(1'b0,  9'sd0,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 1'b0);
      drive(1'b0,  9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4800, 1'b0);
      drive(1'b0,  9'sd2,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5000, 1'b0);
      drive(1'b0, -9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3800, 1'b0);
      drive(1'b1,  9'sd4,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA000, 1'b0);
      idle(1);
      drive(1'b0,  9'sd0,   24'h003000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h4002, 1'b1);
      drive(1'b0,  9'sd56,  24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0);
      idle(5);

      // two values in flight are discarded by a one-cycle reset
      drive(1'b0,  9'sd1,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      drive(1'b0,  9'sd2,   24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      rst          = 1'b1;
      last_posit   = 16'h0000;
      last_inexact = 1'b0;
      idle(1);
      rst = 1'b0;
      idle(6);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL drain observed=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
